// File: rtl/button_duty_ctrl.sv
// Push-button front end: synchronizes and debounces four active-low buttons and
// turns them into saturating, auto-repeating steps on an 8-bit duty command.
module button_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned DUTY_MAX        = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_n,
  input  logic       inc10_n,
  input  logic       dec_n,
  input  logic       dec10_n,
  output logic [7:0] duty,
  output logic       step_pulse,
  output logic       sat
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
  localparam logic [8:0]       DUTY_LIM   = 9'(DUTY_MAX);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  // Bit order: [0] +1, [1] +10, [2] -1, [3] -10
  logic [3:0] btn_n;
  logic [3:0] pressed;
  assign btn_n = {dec10_n, dec_n, inc10_n, inc_n};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [DB_W-1:0] db_cnt_q;

    // The counter measures how long the synced sample has disagreed with the accepted level.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        level_q  <= 1'b1;
        db_cnt_q <= '0;
      end else begin
        sync1_q <= btn_n[gi];
        sync2_q <= sync1_q;
        if (sync2_q == level_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
          level_q  <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end
    end

    assign pressed[gi] = ~level_q;
  end

  function automatic logic [7:0] stepped(input logic [7:0] cur_duty, input logic [3:0] sel);
    logic [8:0] cur;
    logic [8:0] mag;
    logic [8:0] res;
    cur = {1'b0, cur_duty};
    mag = 9'd0;
    res = cur;
    if (sel[0] || sel[1]) begin
      mag = sel[1] ? 9'd10 : 9'd1;
      res = ((cur + mag) > DUTY_LIM) ? DUTY_LIM : (cur + mag);
    end else if (sel[2] || sel[3]) begin
      mag = sel[3] ? 9'd10 : 9'd1;
      res = (cur < mag) ? 9'd0 : (cur - mag);
    end
    return res[7:0];
  endfunction

  state_t           state_q;
  logic [3:0]       latched_q;
  logic [TMR_W-1:0] timer_q;
  logic [7:0]       duty_q;
  logic             step_pulse_q;
  logic             sat_q;

  logic [2:0] press_cnt;
  logic       one_pressed;
  logic       many_pressed;
  logic       hold_ok;
  logic       take_step;
  logic [7:0] step_duty_d;

  assign press_cnt    = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
  assign one_pressed  = (press_cnt == 3'd1);
  assign many_pressed = (press_cnt > 3'd1);
  assign hold_ok      = one_pressed && (pressed == latched_q);
  assign step_duty_d  = stepped(duty_q, (state_q == IDLE) ? pressed : latched_q);

  always_comb begin
    take_step = 1'b0;
    case (state_q)
      IDLE:    take_step = one_pressed;
      HOLD:    take_step = hold_ok && (timer_q == DELAY_LAST);
      REPEAT:  take_step = hold_ok && (timer_q == RATE_LAST);
      default: take_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      latched_q    <= '0;
      timer_q      <= '0;
      duty_q       <= 8'd0;
      step_pulse_q <= 1'b0;
      sat_q        <= 1'b1;
    end else begin
      step_pulse_q <= 1'b0;
      if (take_step) begin
        duty_q       <= step_duty_d;
        step_pulse_q <= (step_duty_d != duty_q);
        sat_q        <= (step_duty_d == 8'd0) || (step_duty_d == DUTY_LIM[7:0]);
      end
      case (state_q)
        IDLE: begin
          if (one_pressed) begin
            state_q   <= HOLD;
            latched_q <= pressed;
            timer_q   <= '0;
          end else if (many_pressed) begin
            state_q <= LOCK;
          end
        end
        HOLD, REPEAT: begin
          // A different lone button re-enters IDLE so it starts its own press cleanly.
          if (press_cnt == 3'd0) begin
            state_q <= IDLE;
          end else if (many_pressed) begin
            state_q <= LOCK;
          end else if (!hold_ok) begin
            state_q <= IDLE;
          end else if (take_step) begin
            state_q <= REPEAT;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          if (press_cnt == 3'd0) state_q <= IDLE;
        end
      endcase
    end
  end

  assign duty       = duty_q;
  assign step_pulse = step_pulse_q;
  assign sat        = sat_q;

endmodule
